morse_decoder: RTL and testbench
================================

MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- TICK_DIV, 5000000: clock50 cycles per timing tick (0.1 s at 50 MHz).
- DASH_TICKS, 5: minimum press length in ticks that classifies as dash.
- GAP_TICKS, 10: released ticks that end a letter.
- MAX_SYM, 5: maximum elements per letter; legal range 1..7.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clock50  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- in  in  1  key, active-low (0 = pressed), asynchronous to clock50.
- dot  out  1  one-cycle pulse when an element is classified as dot.
- dash  out  1  one-cycle pulse when an element is classified as dash.
- sym_len  out  3  number of elements captured in the current letter.
- sym_bits  out  MAX_SYM  captured elements, 1 = dash; newest element in bit 0.
- char_valid  out  1  one-cycle pulse when a letter completes.
- char_code  out  6  decoded letter, held until the next char_valid: 0-25 = A-Z, 26-35 = digits 0-9, 63 = invalid.
- seg7  out  8  display pattern for the last char_code.
- stateLED  out  2  current FSM state encoding.

Function
REQ-003 `in` SHALL pass through a 2-flop synchroniser; `pressed` = NOT(synchronised in).
REQ-004 The tick counter SHALL count 0..TICK_DIV-1 and wrap; `tick` is high for exactly the one cycle in which the count equals TICK_DIV-1.
REQ-005 All FSM decisions SHALL be taken only in tick cycles, except EMIT, which lasts exactly one clock.
REQ-006 The FSM SHALL have four states, encoded IDLE=0, PRESS=1, GAP=2, EMIT=3, and SHALL drive stateLED with the current state.
REQ-007 IDLE: tick with pressed -> PRESS, press_cnt=1.
REQ-008 PRESS, tick with pressed: press_cnt increments and saturates at DASH_TICKS.
REQ-009 PRESS, tick with released, the element is classified and the FSM goes to GAP with gap_cnt=1:
- press_cnt>=DASH_TICKS is a dash; otherwise it is a dot.
- The matching dot/dash pulse is issued in the same cycle.
- sym_bits shifts left with the element entering bit 0.
- sym_len increments, saturating at MAX_SYM.
- If sym_len is already MAX_SYM, the overflow flag is set instead.
REQ-010 GAP: tick with pressed -> PRESS, press_cnt=1. Tick with released -> gap_cnt increments; when gap_cnt reaches GAP_TICKS -> EMIT.
REQ-011 EMIT (one clock):
- char_valid=1.
- char_code = table lookup of (sym_len, sym_bits), or 63 if overflow is set or no table entry exists.
- Next cycle: IDLE, with sym_len, sym_bits, overflow and counters cleared.
REQ-012 Decode table SHALL cover the international Morse letters A-Z and digits 0-9; lookup is by exact length plus bit pattern.
REQ-013 seg7 SHALL register the pattern for char_code in the cycle after char_valid; code 63 shows the error pattern.
REQ-014 A held key SHALL never self-terminate a letter; only release followed by the gap ends a letter.
REQ-015 Reset SHALL take priority over tick and every FSM transition occurring in the same cycle.

Reset
REQ-016 On reset=1 at a clock50 edge:
- state=IDLE; tick counter, press_cnt and gap_cnt = 0.
- sym_len=0, sym_bits=0, overflow=0.
- dot=dash=char_valid=0; char_code=63; seg7 = blank pattern 8'b00000000.
- Synchroniser flops = 1 (released).
REQ-017 Reset asserted mid-letter SHALL discard the partial letter and emit no char_valid.

Structure
REQ-018 Package morse_pkg SHALL hold:
- FSM state encoding.
- char_code constants, including CODE_INVALID=63.
- Morse decode table function.
- seg7 pattern table for codes 0-35, 63 and blank.
REQ-019 Sub-module morse_tick SHALL implement the parametrised tick divider; all other logic stays in morse_decoder.

Verification
Bench parameters: TICK_DIV=4, DASH_TICKS=3, GAP_TICKS=5, MAX_SYM=5.
REQ-020 Press 1 tick, release 6 ticks -> one dot pulse; char_valid with char_code=4 (E); sym_len=1 before clear.
REQ-021 Press 1 tick, gap 1, press 3 ticks, release -> dot then dash; char_code=0 (A). Repeat with presses of 2 and 3 ticks -> dot and dash respectively (threshold boundary).
REQ-022 Five dashes -> char_code=26 (0). Six dots -> overflow; char_code=63; sym_len holds at 5.
REQ-023 Key held for 50 ticks, then released -> single dash pulse and no char_valid until 5 released ticks elapse; char_code=19 (T).
REQ-024 Two elements entered, then reset pulsed for 1 cycle -> all outputs at reset values, no char_valid. A following single dot -> char_code=4.
REQ-025 Input glitch shorter than one tick between tick edges -> no element recorded; after each char_valid, seg7 updates exactly one cycle later.

Source files
------------

// File: rtl/morse_pkg.sv
// morse_pkg -- shared definitions for the Morse key decoder.
//   state_t       : FSM state encoding (also driven onto stateLED).
//   CODE_*        : char_code constants; CODE_INVALID marks an undecodable letter.
//   morse_lookup  : (length, element bits) -> char_code, newest element in bit 0.
//   seg7_pattern  : char_code -> 7-segment pattern {dp,g,f,e,d,c,b,a}, active high.
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2,
    ST_EMIT  = 2'd3
  } state_t;

  // Widest letter the lookup understands; narrower sym_bits are zero-extended.
  localparam int SYM_MAX_W = 7;

  localparam logic [5:0] CODE_A       = 6'd0;
  localparam logic [5:0] CODE_DIGIT0  = 6'd26;
  localparam logic [5:0] CODE_INVALID = 6'd63;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_ERROR = 8'h40;  // lone middle bar

  // Patterns for A-Z followed by 0-9, indexed by char_code.
  localparam logic [7:0] SEG_TABLE [36] = '{
    8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71, 8'h3D, 8'h76, 8'h30, 8'h1E,
    8'h75, 8'h38, 8'h37, 8'h54, 8'h5C, 8'h73, 8'h67, 8'h50, 8'h6D, 8'h78,
    8'h3E, 8'h1C, 8'h7E, 8'h36, 8'h6E, 8'h5B,
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
  };

  // Exact match on length and pattern; dash = 1, first element is the MSB.
  function automatic logic [5:0] morse_lookup(input logic [2:0] len,
                                              input logic [SYM_MAX_W-1:0] bits);
    logic [9:0] key;
    key = {len, bits};
    case (key)
      {3'd2, 7'b0000001}: return 6'd0;   // A .-
      {3'd4, 7'b0001000}: return 6'd1;   // B -...
      {3'd4, 7'b0001010}: return 6'd2;   // C -.-.
      {3'd3, 7'b0000100}: return 6'd3;   // D -..
      {3'd1, 7'b0000000}: return 6'd4;   // E .
      {3'd4, 7'b0000010}: return 6'd5;   // F ..-.
      {3'd3, 7'b0000110}: return 6'd6;   // G --.
      {3'd4, 7'b0000000}: return 6'd7;   // H ....
      {3'd2, 7'b0000000}: return 6'd8;   // I ..
      {3'd4, 7'b0000111}: return 6'd9;   // J .---
      {3'd3, 7'b0000101}: return 6'd10;  // K -.-
      {3'd4, 7'b0000100}: return 6'd11;  // L .-..
      {3'd2, 7'b0000011}: return 6'd12;  // M --
      {3'd2, 7'b0000010}: return 6'd13;  // N -.
      {3'd3, 7'b0000111}: return 6'd14;  // O ---
      {3'd4, 7'b0000110}: return 6'd15;  // P .--.
      {3'd4, 7'b0001101}: return 6'd16;  // Q --.-
      {3'd3, 7'b0000010}: return 6'd17;  // R .-.
      {3'd3, 7'b0000000}: return 6'd18;  // S ...
      {3'd1, 7'b0000001}: return 6'd19;  // T -
      {3'd3, 7'b0000001}: return 6'd20;  // U ..-
      {3'd4, 7'b0000001}: return 6'd21;  // V ...-
      {3'd3, 7'b0000011}: return 6'd22;  // W .--
      {3'd4, 7'b0001001}: return 6'd23;  // X -..-
      {3'd4, 7'b0001011}: return 6'd24;  // Y -.--
      {3'd4, 7'b0001100}: return 6'd25;  // Z --..
      {3'd5, 7'b0011111}: return 6'd26;  // 0 -----
      {3'd5, 7'b0001111}: return 6'd27;  // 1 .----
      {3'd5, 7'b0000111}: return 6'd28;  // 2 ..---
      {3'd5, 7'b0000011}: return 6'd29;  // 3 ...--
      {3'd5, 7'b0000001}: return 6'd30;  // 4 ....-
      {3'd5, 7'b0000000}: return 6'd31;  // 5 .....
      {3'd5, 7'b0010000}: return 6'd32;  // 6 -....
      {3'd5, 7'b0011000}: return 6'd33;  // 7 --...
      {3'd5, 7'b0011100}: return 6'd34;  // 8 ---..
      {3'd5, 7'b0011110}: return 6'd35;  // 9 ----.
      default:            return CODE_INVALID;
    endcase
  endfunction

  function automatic logic [7:0] seg7_pattern(input logic [5:0] code);
    if (code < 6'd36)            return SEG_TABLE[code];
    else if (code == CODE_INVALID) return SEG_ERROR;
    else                         return SEG_BLANK;
  endfunction

endpackage

// File: rtl/morse_tick.sv
// morse_tick -- free-running divider producing the decoder's timing tick.
//   clock50 : clock.
//   reset   : synchronous, active-high; clears the count.
//   tick    : high for the single cycle in which the count equals TICK_DIV-1.
module morse_tick #(
  parameter int TICK_DIV = 5000000
) (
  input  logic clock50,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clock50) begin
    if (reset)              count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + CW'(1);
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/morse_decoder.sv
// morse_decoder -- decodes a single Morse key into letters/digits.
//   clock50    : clock.            reset      : synchronous, active-high.
//   in         : key, active-low, asynchronous.
//   dot / dash : one-cycle pulse when an element is classified.
//   sym_len    : elements captured in the current letter.
//   sym_bits   : captured elements, 1 = dash, newest in bit 0.
//   char_valid : one-cycle pulse when a letter completes.
//   char_code  : decoded letter (0-25 A-Z, 26-35 digits, 63 invalid), held.
//   seg7       : display pattern for the last char_code.
//   stateLED   : current FSM state.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int TICK_DIV   = 5000000,
  parameter int DASH_TICKS = 5,
  parameter int GAP_TICKS  = 10,
  parameter int MAX_SYM    = 5
) (
  input  logic               clock50,
  input  logic               reset,
  input  logic               in,
  output logic               dot,
  output logic               dash,
  output logic [2:0]         sym_len,
  output logic [MAX_SYM-1:0] sym_bits,
  output logic               char_valid,
  output logic [5:0]         char_code,
  output logic [7:0]         seg7,
  output logic [1:0]         stateLED
);

  localparam int PW = $clog2(DASH_TICKS + 1);
  localparam int GW = $clog2(GAP_TICKS + 1);

  logic               sync1, sync2, pressed, tick, is_dash;
  state_t             state, state_next;
  logic [PW-1:0]      press_cnt, press_cnt_next;
  logic [GW-1:0]      gap_cnt, gap_cnt_next;
  logic [2:0]         sym_len_next;
  logic [MAX_SYM-1:0] sym_bits_next;
  logic               overflow, overflow_next;
  logic               dot_c, dash_c, emit_c;
  logic [5:0]         code_q, decoded;

  morse_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock50 (clock50),
    .reset   (reset),
    .tick    (tick)
  );

  // Synchroniser resets to the released level so no phantom press follows reset.
  always_ff @(posedge clock50) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
    end
  end

  assign pressed = ~sync2;
  assign is_dash = (press_cnt >= PW'(DASH_TICKS));
  assign decoded = overflow ? CODE_INVALID
                            : morse_lookup(sym_len, SYM_MAX_W'(sym_bits));

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves a latch.
    state_next     = state;
    press_cnt_next = press_cnt;
    gap_cnt_next   = gap_cnt;
    sym_len_next   = sym_len;
    sym_bits_next  = sym_bits;
    overflow_next  = overflow;
    dot_c          = 1'b0;
    dash_c         = 1'b0;
    emit_c         = 1'b0;
    case (state)
      ST_IDLE: if (tick && pressed) begin
        state_next     = ST_PRESS;
        press_cnt_next = PW'(1);
      end
      ST_PRESS: if (tick) begin
        if (pressed) begin
          // Saturating keeps a long hold a dash without ending the letter.
          if (!is_dash) press_cnt_next = press_cnt + PW'(1);
        end else begin
          dot_c        = ~is_dash;
          dash_c       = is_dash;
          state_next   = ST_GAP;
          gap_cnt_next = GW'(1);
          if (sym_len == 3'(MAX_SYM)) begin
            overflow_next = 1'b1;
          end else begin
            sym_bits_next = MAX_SYM'({sym_bits, is_dash});
            sym_len_next  = sym_len + 3'd1;
          end
        end
      end
      ST_GAP: if (tick) begin
        if (pressed) begin
          state_next     = ST_PRESS;
          press_cnt_next = PW'(1);
        end else begin
          gap_cnt_next = gap_cnt + GW'(1);
          if (gap_cnt + GW'(1) >= GW'(GAP_TICKS)) state_next = ST_EMIT;
        end
      end
      ST_EMIT: begin
        emit_c         = 1'b1;
        state_next     = ST_IDLE;
        press_cnt_next = '0;
        gap_cnt_next   = '0;
        sym_len_next   = '0;
        sym_bits_next  = '0;
        overflow_next  = 1'b0;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock50) begin
    if (reset) begin
      state     <= ST_IDLE;
      press_cnt <= '0;
      gap_cnt   <= '0;
      sym_len   <= '0;
      sym_bits  <= '0;
      overflow  <= 1'b0;
      code_q    <= CODE_INVALID;
      seg7      <= SEG_BLANK;
    end else begin
      state     <= state_next;
      press_cnt <= press_cnt_next;
      gap_cnt   <= gap_cnt_next;
      sym_len   <= sym_len_next;
      sym_bits  <= sym_bits_next;
      overflow  <= overflow_next;
      if (emit_c) begin
        code_q <= decoded;
        seg7   <= seg7_pattern(decoded);
      end
    end
  end

  // Pulses are masked while reset is high so an aborted letter never reports.
  assign dot        = dot_c  & ~reset;
  assign dash       = dash_c & ~reset;
  assign char_valid = emit_c & ~reset;
  // The fresh code is visible alongside char_valid and held afterwards.
  assign char_code  = char_valid ? decoded : code_q;
  assign stateLED   = state;

endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder -- randomized and directed letters checked against a
// string-based Morse reference (element strings looked up in a table).
module tb_morse_decoder;

  localparam int TICK_DIV   = 4;
  localparam int DASH_TICKS = 3;
  localparam int GAP_TICKS  = 5;
  localparam int MAX_SYM    = 5;

  logic               clock50 = 1'b0;
  logic               reset   = 1'b1;
  logic               in      = 1'b1;
  logic               dot, dash, char_valid;
  logic [2:0]         sym_len;
  logic [MAX_SYM-1:0] sym_bits;
  logic [5:0]         char_code;
  logic [7:0]         seg7;
  logic [1:0]         stateLED;

  morse_decoder #(
    .TICK_DIV(TICK_DIV), .DASH_TICKS(DASH_TICKS),
    .GAP_TICKS(GAP_TICKS), .MAX_SYM(MAX_SYM)
  ) dut (
    .clock50(clock50), .reset(reset), .in(in), .dot(dot), .dash(dash),
    .sym_len(sym_len), .sym_bits(sym_bits), .char_valid(char_valid),
    .char_code(char_code), .seg7(seg7), .stateLED(stateLED)
  );

  always #5 clock50 = ~clock50;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  string morse_tab [36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."
  };
  logic [7:0] seg_tab [36] = '{
    8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71, 8'h3D, 8'h76, 8'h30, 8'h1E,
    8'h75, 8'h38, 8'h37, 8'h54, 8'h5C, 8'h73, 8'h67, 8'h50, 8'h6D, 8'h78,
    8'h3E, 8'h1C, 8'h7E, 8'h36, 8'h6E, 8'h5B,
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
  };

  function automatic int ref_code(input string s);
    if (s.len() > MAX_SYM) return 63;
    for (int i = 0; i < 36; i++) if (s == morse_tab[i]) return i;
    return 63;
  endfunction

  function automatic logic [7:0] ref_seg(input logic [5:0] code);
    if (code == 6'd63) return 8'h40;
    if (code < 6'd36)  return seg_tab[code];
    return 8'h00;
  endfunction

  // Tick phase as the divider rule defines it, used only to place a glitch.
  int tcnt = 0;
  always @(posedge clock50) begin
    if (reset) tcnt <= 0;
    else       tcnt <= (tcnt == TICK_DIV - 1) ? 0 : tcnt + 1;
  end

  // ---------------- output monitor ----------------
  bit         elem_q [$];
  logic [5:0] cv_q   [$];
  logic [2:0] len_q  [$];
  logic [7:0] prev_seg = 8'h00;
  logic [5:0] last_code = 6'd63;
  bit         seg_pending = 1'b0;

  always @(negedge clock50) begin
    if (!reset) begin
      if (dot || dash) begin
        check("dot_dash_exclusive", {31'd0, dot & dash}, 32'd0);
        elem_q.push_back(dash);
      end
      if (seg_pending) begin
        check("seg7_after_char", {24'd0, seg7}, {24'd0, ref_seg(last_code)});
        seg_pending <= 1'b0;
      end
      if (char_valid) begin
        cv_q.push_back(char_code);
        len_q.push_back(sym_len);
        check("seg7_hold_in_valid", {24'd0, seg7}, {24'd0, prev_seg});
        last_code   <= char_code;
        seg_pending <= 1'b1;
      end
    end
    prev_seg <= seg7;
  end

  // ---------------- stimulus ----------------
  int pq [$];  // press length of each element, ticks
  int gq [$];  // release after each element, ticks (last one ends the letter)

  task automatic drive(input logic v, input int cycles);
    in = v;
    repeat (cycles) @(negedge clock50);
  endtask

  task automatic clear_obs();
    elem_q.delete();
    cv_q.delete();
    len_q.delete();
  endtask

  task automatic play_letter(input string tag);
    string s, d;
    int    code, n_exp;
    s = "";
    clear_obs();
    for (int i = 0; i < pq.size(); i++) begin
      drive(1'b0, pq[i] * TICK_DIV);
      drive(1'b1, gq[i] * TICK_DIV);
      d = (pq[i] >= DASH_TICKS) ? "-" : ".";
      s = {s, d};
    end
    drive(1'b1, 8);
    code  = ref_code(s);
    n_exp = (s.len() > MAX_SYM) ? MAX_SYM : s.len();
    check({tag, "_elem_count"}, elem_q.size(), pq.size());
    if (elem_q.size() == pq.size())
      for (int i = 0; i < pq.size(); i++)
        check({tag, "_elem_kind"}, {31'd0, elem_q[i]}, {31'd0, pq[i] >= DASH_TICKS});
    check({tag, "_char_valid_count"}, cv_q.size(), 1);
    if (cv_q.size() == 1) begin
      check({tag, "_char_code"}, {26'd0, cv_q[0]}, code);
      check({tag, "_sym_len"}, {29'd0, len_q[0]}, n_exp);
    end
    check({tag, "_code_held"}, {26'd0, char_code}, code);
    check({tag, "_back_idle"}, {30'd0, stateLED}, 0);
    check({tag, "_len_cleared"}, {29'd0, sym_len}, 0);
  endtask

  task automatic set_letter(input int n, input int press_len, input int gap);
    pq.delete();
    gq.delete();
    for (int i = 0; i < n; i++) begin
      pq.push_back(press_len);
      gq.push_back((i == n - 1) ? GAP_TICKS + 1 : gap);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_dot"},        {31'd0, dot}, 0);
    check({tag, "_dash"},       {31'd0, dash}, 0);
    check({tag, "_char_valid"}, {31'd0, char_valid}, 0);
    check({tag, "_char_code"},  {26'd0, char_code}, 63);
    check({tag, "_seg7"},       {24'd0, seg7}, 0);
    check({tag, "_sym_len"},    {29'd0, sym_len}, 0);
    check({tag, "_sym_bits"},   {27'd0, sym_bits}, 0);
    check({tag, "_state"},      {30'd0, stateLED}, 0);
  endtask

  initial begin
    repeat (3) @(negedge clock50);
    reset = 1'b0;
    #1 check_reset_values("reset");
    @(negedge clock50);

    // Single short press: E.
    set_letter(1, 1, 1);
    play_letter("E");

    // Dot then dash: A; then second press at 2 and 3 ticks (threshold).
    pq = '{1, 3}; gq = '{1, 6}; play_letter("A");
    pq = '{1, 2}; gq = '{1, 6}; play_letter("I_thresh2");
    pq = '{1, 3}; gq = '{1, 6}; play_letter("A_thresh3");

    // Five dashes: digit 0.  Six dots: overflow.
    set_letter(5, 3, 2);
    play_letter("digit0");
    set_letter(6, 1, 1);
    play_letter("overflow");

    // Held key: one dash, no letter until the gap elapses.
    clear_obs();
    drive(1'b0, 50 * TICK_DIV);
    check("hold_state_press", {30'd0, stateLED}, 1);
    check("hold_no_elem", elem_q.size(), 0);
    check("hold_no_char", cv_q.size(), 0);
    drive(1'b1, 2 * TICK_DIV);
    check("hold_one_elem", elem_q.size(), 1);
    if (elem_q.size() == 1) check("hold_is_dash", {31'd0, elem_q[0]}, 1);
    check("hold_no_char_yet", cv_q.size(), 0);
    drive(1'b1, 4 * TICK_DIV + 8);
    check("hold_char_count", cv_q.size(), 1);
    if (cv_q.size() == 1) check("hold_char_T", {26'd0, cv_q[0]}, 19);

    // Reset in mid-letter discards it.
    clear_obs();
    drive(1'b0, 1 * TICK_DIV);
    drive(1'b1, 1 * TICK_DIV);
    drive(1'b0, 3 * TICK_DIV);
    drive(1'b1, 3 * TICK_DIV);
    check("midrst_two_elems", elem_q.size(), 2);
    check("midrst_len_before", {29'd0, sym_len}, 2);
    reset = 1'b1;
    @(negedge clock50);
    reset = 1'b0;
    #1 check_reset_values("midrst");
    drive(1'b1, 8 * TICK_DIV);
    check("midrst_no_char", cv_q.size(), 0);
    set_letter(1, 1, 1);
    play_letter("E_after_reset");

    // Glitch confined between tick cycles must not register.
    clear_obs();
    begin
      int tries;
      tries = 0;
      while (tcnt != TICK_DIV - 1 && tries < 2 * TICK_DIV) begin
        @(negedge clock50);
        tries++;
      end
      check("glitch_phase_found", {31'd0, tcnt == TICK_DIV - 1}, 1);
    end
    drive(1'b0, 2);
    drive(1'b1, 8 * TICK_DIV);
    check("glitch_no_elem", elem_q.size(), 0);
    check("glitch_no_char", cv_q.size(), 0);
    check("glitch_idle", {30'd0, stateLED}, 0);

    // Randomized letters.
    for (int r = 0; r < 16; r++) begin
      int n;
      n = $urandom_range(1, 6);
      pq.delete();
      gq.delete();
      for (int i = 0; i < n; i++) begin
        pq.push_back($urandom_range(1, 5));
        gq.push_back((i == n - 1) ? $urandom_range(GAP_TICKS, GAP_TICKS + 2)
                                  : $urandom_range(1, GAP_TICKS - 1));
      end
      play_letter($sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
